bitser_tx: RTL and testbench
============================

BITSER_TX -- requirements
Module: bitser_tx

Interface
REQ-001 Parameter W, default 8, maximum word width in bits (W >= 1).
REQ-002 Parameter PW, default $clog2(W)+1, width of the prec port.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 clr_n  input  1  reset, synchronous, active-low.
REQ-005 step  input  1  advance enable; one serial bit is consumed per cycle in which step=1 and out_valid=1.
REQ-006 prec  input  PW  precision, i.e. bits per word; sampled when a word enters the shifter.
REQ-007 in_valid  input  1  parallel word offered.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 in_data  input  W  parallel word; only the low P bits are transmitted.
REQ-010 out  output  1  current serial bit.
REQ-011 out_valid  output  1  out holds a valid bit.
REQ-012 out_first  output  1  current bit is the first bit of its word.
REQ-013 out_last  output  1  current bit is the last bit of its word.
REQ-014 busy  output  1  out_valid OR holding register full.

Function
REQ-015 Effective precision P = W when prec=0 or prec>W; otherwise P = prec.
REQ-016 A word is accepted on a cycle where in_valid=1 and in_ready=1; in_ready = NOT hold_full (a one-entry holding register).
REQ-017 States: IDLE (shifter empty, out_valid=0) and SHIFT (shifter loaded, out_valid=1).
REQ-018 Shifter loading, evaluated in priority order:
- (a) if the shifter is empty or finishing this cycle, and hold_full, the held word loads.
- (b) otherwise, if the shifter is empty or finishing and a word is accepted, the accepted word loads directly.
- (c) otherwise, an accepted word is written to the holding register.
REQ-019 "Finishing" = SHIFT AND step=1 AND out_last=1.
REQ-020 Latency: a word accepted in IDLE with the hold empty drives out_valid=1 and its first bit on the next cycle.
REQ-021 Transmission order is MSB-first: bit P-1 of the loaded word first, bit 0 last.
REQ-022 On load, a bit counter is set to P-1 and P is latched; a later change on prec does not affect a word already in the shifter.
REQ-023 Each consumed bit shifts the next bit onto out and decrements the counter.
REQ-024 out_first=1 exactly on the first bit of each word; out_last=1 when the counter = 0. P=1 asserts both together.
REQ-025 When the last bit is consumed: with a word available (held or accepted), the state stays SHIFT with no bubble; otherwise the state goes to IDLE.
REQ-026 step=0 holds out, out_first, out_last and the counter stable.
REQ-027 step in IDLE has no effect.
REQ-028 When out_valid=0, out, out_first and out_last are 0.
REQ-029 Simultaneous accept and finish with the hold full: the held word loads into the shifter and the accepted word enters the hold; no word is lost or reordered.

Reset
REQ-030 clr_n=0 at a clock edge clears the shifter, counter, latched P, hold_full and state (state to IDLE).
REQ-031 Outputs on the cycle after reset: out=0, out_valid=0, out_first=0, out_last=0, busy=0, in_ready=1.
REQ-032 While clr_n=0, handshakes are ignored and no word is accepted.
REQ-033 Reset mid-word discards both the partial word and any held word; no further bits of them appear.

Verification
REQ-034 W=8, prec=8, accept 0xA5, step=1 continuously -> out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after accept; first on bit 1, last on bit 8; then out_valid=0.
REQ-035 prec=3, data 0xFD -> out = 1,0,1 with last on the 3rd bit; prec=0, data 0x81 -> 8 bits 1,0,0,0,0,0,0,1.
REQ-036 Back-to-back 0xF0 then 0x0F, prec=8, step=1, in_valid held -> 16 contiguous valid bits 11110000 00001111; first asserted at bits 1 and 9, no gap; in_ready=0 while the hold is full.
REQ-037 step toggles 1,0,1,0 on 0xC3 -> each bit is held during step=0 cycles; sequence 1,1,0,0,0,0,1,1 preserved.
REQ-038 Accept 0xAA and 0x55 (hold full), assert clr_n=0 after 3 bits -> the next cycle after reset shows out_valid=0, busy=0, in_ready=1; the next accepted 0xFF emits eight 1s only.
REQ-039 prec=1, accept 0x01 and 0x00 back-to-back -> out = 1,0 on consecutive cycles, each with first=last=1.

Source files
------------

// File: rtl/bitser_tx.sv
// MSB-first parallel-to-serial transmitter with a one-word holding register
// and per-word programmable precision latched when the word enters the shifter.
module bitser_tx #(
    parameter int W  = 8,
    parameter int PW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          step,
    input  logic [PW-1:0] prec,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out,
    output logic          out_valid,
    output logic          out_first,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [PW-1:0] W_P   = PW'(W);
    localparam logic [PW-1:0] ONE_P = PW'(1);

    state_t         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [PW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  p_q, p_d;
    logic [W-1:0]   hold_q, hold_d;
    logic           hold_full_q, hold_full_d;

    logic           shifting;
    logic           accept;
    logic           finishing;
    logic           free;
    logic           load;
    logic [W-1:0]   load_data;
    logic [PW-1:0]  p_eff;

    assign shifting  = (state_q == SHIFT);
    assign in_ready  = ~hold_full_q;
    assign accept    = in_valid & ~hold_full_q;
    assign out_valid = shifting;
    assign out       = shifting & shreg_q[W-1];
    assign out_last  = shifting && (cnt_q == '0);
    assign out_first = shifting && (cnt_q == p_q - ONE_P);
    assign busy      = shifting | hold_full_q;
    assign finishing = out_last & step;
    assign free      = ~shifting | finishing;

    always_comb begin
        p_eff = prec;
        if (prec == '0 || prec > W_P) begin
            p_eff = W_P;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        load_data   = in_data;

        // The held word always goes first so words leave in acceptance order.
        if (free && hold_full_q) begin
            load        = 1'b1;
            load_data   = hold_q;
            hold_full_d = accept;
            if (accept) begin
                hold_d = in_data;
            end
        end else if (free && accept) begin
            load = 1'b1;
        end else if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        // Left-justify the word so bit P-1 sits at the MSB and drives out.
        if (load) begin
            state_d = SHIFT;
            shreg_d = load_data << (W_P - p_eff);
            cnt_d   = p_eff - ONE_P;
            p_d     = p_eff;
        end else if (finishing) begin
            state_d = IDLE;
        end else if (shifting && step) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - ONE_P;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_bitser_tx.sv
// Scoreboard bench for bitser_tx: accepted words expand into expected bit
// records; a negedge monitor compares and retires them as bits are consumed.
module tb_bitser_tx;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          step;
    logic [PW-1:0] prec;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic          busy;

    bitser_tx #(.W(W), .PW(PW)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .step      (step),
        .prec      (prec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out       (out),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic f;
        logic l;
        int   wid;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wid_n  = 0;
    bit   mon_en = 0;
    bit   ne;
    bit   holdm;

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, req, $time);
        end
    endtask

    // Expected bits of one word: P bits, MSB (bit P-1) first.
    function automatic void push_word(input logic [W-1:0] d, input logic [PW-1:0] p);
        int pe;
        pe = int'(p);
        if (pe == 0 || pe > W) pe = W;
        for (int i = pe - 1; i >= 0; i--) begin
            exp_q.push_back('{d[i], (i == pe - 1), (i == 0), wid_n});
        end
        wid_n++;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            ne    = exp_q.size() > 0;
            holdm = ne && (exp_q[$].wid != exp_q[0].wid);
            chk("out_valid", out_valid, ne);
            chk("busy", busy, ne);
            chk("in_ready", in_ready, !holdm);
            if (ne) begin
                chk("out", out, exp_q[0].b);
                chk("out_first", out_first, exp_q[0].f);
                chk("out_last", out_last, exp_q[0].l);
                if (step) void'(exp_q.pop_front());
            end else begin
                chk("out_idle", out, 1'b0);
                chk("first_idle", out_first, 1'b0);
                chk("last_idle", out_last, 1'b0);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic drive(input bit v, input logic [W-1:0] d, input logic [PW-1:0] p,
                         input bit s, input bit r);
        bit acc;
        in_valid = v;
        in_data  = d;
        prec     = p;
        step     = s;
        clr_n    = r;
        acc      = v && (in_ready === 1'b1) && r;
        @(posedge clk);
        if (!r) exp_q.delete();
        else if (acc) push_word(d, p);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            drive(0, '0, prec, 1, 1);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 bits left", exp_q.size());
            exp_q.delete();
        end
        drive(0, '0, prec, 1, 1);
    endtask

    logic [PW-1:0] pr;
    bit            rv, rs, rr;

    initial begin
        clr_n    = 1'b0;
        step     = 1'b0;
        prec     = PW'(8);
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;
        drive(0, '0, PW'(8), 0, 0);
        mon_en = 1;
        drive(0, '0, PW'(8), 1, 1);

        drive(1, 8'hA5, PW'(8), 1, 1);
        drain();

        drive(1, 8'hFD, PW'(3), 1, 1);
        drain();
        drive(1, 8'h81, PW'(0), 1, 1);
        drain();

        drive(1, 8'hF0, PW'(8), 1, 1);
        drive(1, 8'h0F, PW'(8), 1, 1);
        drain();

        drive(1, 8'hC3, PW'(8), 1, 1);
        for (int i = 0; i < 16; i++) drive(0, '0, PW'(8), (i % 2) == 1, 1);
        drain();

        drive(1, 8'hAA, PW'(8), 1, 1);
        drive(1, 8'h55, PW'(8), 1, 1);
        drive(0, '0, PW'(8), 1, 1);
        drive(0, '0, PW'(8), 1, 1);
        drive(1, 8'h33, PW'(8), 1, 0);
        drive(0, '0, PW'(8), 1, 1);
        drive(1, 8'hFF, PW'(8), 1, 1);
        drain();

        // Precision change while a word is in the shifter must not affect it.
        drive(1, 8'hA5, PW'(8), 1, 1);
        drive(0, '0, PW'(3), 1, 1);
        drain();

        drive(1, 8'h01, PW'(1), 1, 1);
        drive(1, 8'h00, PW'(1), 1, 1);
        drain();

        drive(1, 8'h5A, PW'(12), 0, 1);
        drive(1, 8'h3C, PW'(12), 0, 1);
        drive(1, 8'h99, PW'(12), 0, 1);
        drain();

        pr = PW'(8);
        for (int i = 0; i < 800; i++) begin
            rv = $urandom_range(0, 2) != 0;
            rs = $urandom_range(0, 3) != 0;
            rr = $urandom_range(0, 99) != 0;
            if (!rv && in_ready === 1'b1) pr = PW'($urandom_range(0, 15));
            drive(rv, W'($urandom), pr, rs, rr);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
